// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (shift-add / restoring divide).
// Optional signed MULT/DIV support is built when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_muldiv,
  input  logic [1:0]       muldiv_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_stream,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic [WIDTH-1:0]   hi, lo;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               last_step;

`ifdef MULDIV_SIGNED_EN
  logic neg_a, neg_b;

  always_comb begin
    abs_a = (muldiv_ctrl[0] && a[WIDTH-1]) ? -a : a;
    abs_b = (muldiv_ctrl[0] && b[WIDTH-1]) ? -b : b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else if (state == IDLE && we_muldiv) begin
      neg_a <= muldiv_ctrl[0] & a[WIDTH-1];
      neg_b <= muldiv_ctrl[0] & b[WIDTH-1];
    end
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = muldiv_ctrl[0];

  always_comb begin
    abs_a = a;
    abs_b = b;
  end
`endif

  // Multiply: upper half accumulates, lower half shifts out the multiplier.
  // Divide: upper half is the partial remainder, lower half shifts dividend in / quotient out.
  always_comb begin
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, work[WIDTH-1:1]};
    div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (div_diff[WIDTH])
      div_next = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    step_next = is_div ? div_next : mul_next;
  end

  always_comb begin
    res_hi = step_next[2*WIDTH-1:WIDTH];
    res_lo = step_next[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (is_div) begin
      // A zero divisor keeps the all-ones quotient regardless of the dividend sign.
      if (neg_a ^ neg_b && opnd != '0)
        res_lo = -step_next[WIDTH-1:0];
      if (neg_a)
        res_hi = -step_next[2*WIDTH-1:WIDTH];
    end else if (neg_a ^ neg_b) begin
      {res_hi, res_lo} = -step_next;
    end
`endif
  end

  assign last_step = (state == RUN) && (count == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (we_muldiv) state_d = RUN;
      RUN:     if (count == CW'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      work   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (state == IDLE && we_muldiv) begin
        count  <= CW'(WIDTH);
        is_div <= muldiv_ctrl[1];
        work   <= {{WIDTH{1'b0}}, (muldiv_ctrl[1] ? abs_a : abs_b)};
        opnd   <= muldiv_ctrl[1] ? abs_b : abs_a;
      end else if (state == RUN) begin
        count <= count - CW'(1);
        work  <= step_next;
      end
      if (last_step) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  assign hilo_out = hilo_stream ? hi : lo;
  assign busy     = (state == RUN);
  assign done     = (state == FINISH);

endmodule
